// File: rtl/reward_eval_seq.sv
// Sequential N x N board reward evaluator: scans one winning line per clock, then reports reward and status.
// Latency 2N+2 scan cycles after acceptance; the result holds in DONE until out_ready, and no new board is accepted meanwhile.
module reward_eval_seq #(
    parameter int N      = 3,
    parameter int RW     = 8,
    parameter int R_WIN  = 2,
    parameter int R_LOSE = -2,
    parameter int R_FULL = 0,
    parameter int R_CONT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*N*N-1:0]  state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     reward,
    output logic [1:0]        status,
    output logic              bad_cell
);

    localparam int L  = 2*N + 2;
    localparam int IW = $clog2(L);

    localparam logic [RW-1:0] RV_WIN  = RW'(R_WIN);
    localparam logic [RW-1:0] RV_LOSE = RW'(R_LOSE);
    localparam logic [RW-1:0] RV_FULL = RW'(R_FULL);
    localparam logic [RW-1:0] RV_CONT = RW'(R_CONT);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;

    fsm_t              cur, nxt;
    logic [2*N*N-1:0]  board;
    logic [IW-1:0]     idx;
    logic              win_a, win_o;
    logic              line_a, line_o, any_empty, any_bad, last;
    logic              fin_a, fin_o;

    // Cell coordinates of line idx: rows, then columns, then main and anti diagonal.
    always_comb begin
        int r, c;
        r      = 0;
        c      = 0;
        line_a = 1'b1;
        line_o = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) < N) begin
                r = int'(idx);
                c = k;
            end else if (int'(idx) < 2*N) begin
                r = k;
                c = int'(idx) - N;
            end else if (int'(idx) == 2*N) begin
                r = k;
                c = k;
            end else begin
                r = k;
                c = N - 1 - k;
            end
            line_a = line_a && (board[2*(r*N+c) +: 2] == 2'b01);
            line_o = line_o && (board[2*(r*N+c) +: 2] == 2'b10);
        end
    end

    always_comb begin
        any_empty = 1'b0;
        any_bad   = 1'b0;
        for (int i = 0; i < N*N; i++) begin
            any_empty = any_empty || (board[2*i +: 2] == 2'b00);
            any_bad   = any_bad   || (board[2*i +: 2] == 2'b11);
        end
    end

    assign last  = (int'(idx) == L - 1);
    assign fin_a = win_a || line_a;
    assign fin_o = win_o || line_o;

    always_comb begin
        nxt       = cur;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (cur)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) nxt = SCAN;
            end
            SCAN: if (last) nxt = DONE;
            DONE: begin
                out_valid = !rst;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            board    <= '0;
            idx      <= '0;
            win_a    <= 1'b0;
            win_o    <= 1'b0;
            reward   <= '0;
            status   <= 2'b00;
            bad_cell <= 1'b0;
        end else begin
            cur <= nxt;
            case (cur)
                IDLE: if (nxt == SCAN) begin
                    board <= state;
                    idx   <= '0;
                    win_a <= 1'b0;
                    win_o <= 1'b0;
                end
                SCAN: begin
                    win_a <= fin_a;
                    win_o <= fin_o;
                    idx   <= last ? '0 : idx + IW'(1);
                    // The final line is folded in directly since the sticky flags lag by one cycle.
                    if (last) begin
                        bad_cell <= any_bad;
                        if (fin_a) begin
                            reward <= RV_WIN;
                            status <= 2'b10;
                        end else if (fin_o) begin
                            reward <= RV_LOSE;
                            status <= 2'b11;
                        end else if (!any_empty) begin
                            reward <= RV_FULL;
                            status <= 2'b01;
                        end else begin
                            reward <= RV_CONT;
                            status <= 2'b00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reward_eval_seq.sv
// Directed bench for reward_eval_seq: N=3 and N=4 instances, latency, priority, back-pressure and abort.
module tb_reward_eval_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv3 = 1'b0, or3 = 1'b0;
    logic [17:0] st3 = '0;
    logic        ir3, ov3, bc3;
    logic [7:0]  rw3;
    logic [1:0]  ss3;

    logic        iv4 = 1'b0, or4 = 1'b0;
    logic [31:0] st4 = '0;
    logic        ir4, ov4, bc4;
    logic [7:0]  rw4;
    logic [1:0]  ss4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reward_eval_seq #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .state(st3),
        .out_valid(ov3), .out_ready(or3), .reward(rw3), .status(ss3), .bad_cell(bc3)
    );

    reward_eval_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .state(st4),
        .out_valid(ov4), .out_ready(or4), .reward(rw4), .status(ss4), .bad_cell(bc4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency is reported as the cycle index after the accept edge in which out_valid is first seen.
    task automatic run3(input string tag, input logic [17:0] b, input logic [7:0] er,
                        input logic [1:0] es, input logic eb);
        int lat;
        @(negedge clk);
        st3 = b;
        iv3 = 1'b1;
        or3 = 1'b1;
        check({tag, "_rdy"}, 32'(ir3), 32'd1);
        @(posedge clk);
        #1 iv3 = 1'b0;
        lat = 1;
        while (!ov3 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_rew"}, 32'(rw3), 32'(er));
        check({tag, "_sts"}, 32'(ss3), 32'(es));
        check({tag, "_bad"}, 32'(bc3), 32'(eb));
        @(posedge clk);
        #1;
        check({tag, "_ovlo"}, 32'(ov3), 32'd0);
        check({tag, "_rdy2"}, 32'(ir3), 32'd1);
    endtask

    initial begin
        int lat, cnt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy3", 32'(ir3), 32'd0);
        check("rst_rdy4", 32'(ir4), 32'd0);
        check("rst_ov3", 32'(ov3), 32'd0);
        check("rst_rew3", 32'(rw3), 32'd0);
        check("rst_sts3", 32'(ss3), 32'd0);
        check("rst_bad3", 32'(bc3), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy3", 32'(ir3), 32'd1);
        check("post_rst_ov4", 32'(ov4), 32'd0);

        run3("agent_row0", 18'h00015, 8'h02, 2'b10, 1'b0);
        run3("opp_diag",   18'h20202, 8'hFE, 2'b11, 1'b0);
        run3("full_draw",  18'h26999, 8'h00, 2'b01, 1'b0);
        run3("one_empty",  18'h06999, 8'h01, 2'b00, 1'b0);
        run3("both_lines", 18'h2A015, 8'h02, 2'b10, 1'b0);
        run3("bad_cell",   18'h00300, 8'h01, 2'b00, 1'b1);

        // N=4 anti-diagonal with back-pressure and ignored in_valid pulses
        @(negedge clk);
        st4 = 32'h0104_1040;
        iv4 = 1'b1;
        or4 = 1'b0;
        check("n4_rdy", 32'(ir4), 32'd1);
        @(posedge clk);
        #1 iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check("n4_lat", 32'(lat), 32'd11);
        check("n4_rew", 32'(rw4), 32'd2);
        check("n4_sts", 32'(ss4), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv4 = 1'b1;
            st4 = 32'h0000_00AA;
            check("n4_hold_ov", 32'(ov4), 32'd1);
            check("n4_hold_rew", 32'(rw4), 32'd2);
            check("n4_hold_sts", 32'(ss4), 32'd2);
            check("n4_hold_rdy", 32'(ir4), 32'd0);
        end
        @(negedge clk);
        iv4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk);
        #1;
        check("n4_take_ov", 32'(ov4), 32'd0);
        check("n4_take_rdy", 32'(ir4), 32'd1);
        check("n4_idle_sts", 32'(ss4), 32'd2);
        cnt = 0;
        repeat (14) begin
            @(posedge clk);
            #1 if (ov4) cnt++;
        end
        check("n4_no_queue", 32'(cnt), 32'd0);

        // Abort in the fourth SCAN cycle; previous result (reward 1, bad_cell 1) must be cleared
        @(negedge clk);
        st3 = 18'h00015;
        iv3 = 1'b1;
        @(posedge clk);
        #1 iv3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("abort_rdy_in_rst", 32'(ir3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rdy", 32'(ir3), 32'd1);
        check("abort_ov", 32'(ov3), 32'd0);
        check("abort_rew", 32'(rw3), 32'd0);
        check("abort_sts", 32'(ss3), 32'd0);
        check("abort_bad", 32'(bc3), 32'd0);
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (ov3) cnt++;
        end
        check("abort_no_ov", 32'(cnt), 32'd0);
        run3("after_abort", 18'h20202, 8'hFE, 2'b11, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reward_eval_seq.md
# reward_eval_seq

Parametrised, sequential successor to the tic-tac-toe reward generator. Accepts an N×N board snapshot over a valid/ready handshake, scans one winning line per clock (rows, columns, both diagonals), and returns a signed reward plus a 2-bit game status. It sits between the board/state register and the Q-learning update datapath, replacing the single-cycle combinational reward decode for boards larger than 3×3.

## Interface
- `N`, 3: board dimension (N×N cells), N ≥ 3.
- `RW`, 8: reward width, two's complement.
- `R_WIN`, 2: reward when the agent (code 1) has a complete line.
- `R_LOSE`, -2: reward when the opponent (code 2) has a complete line.
- `R_FULL`, 0: reward when the board is full with no line.
- `R_CONT`, 1: reward when no line exists and at least one cell is empty.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  board snapshot valid.
- `in_ready`  out  1  block idle, can accept.
- `state`  in  2·N·N  board; cell (r,c) at bits [2(rN+c)+1 : 2(rN+c)]; 00 empty, 01 agent, 10 opponent, 11 invalid.
- `out_valid`  out  1  result valid, held until taken.
- `out_ready`  in  1  consumer takes result.
- `reward`  out  RW  signed reward.
- `status`  out  2  00 continue, 01 draw/full, 10 agent won, 11 agent lost.
- `bad_cell`  out  1  snapshot contained at least one 11 cell.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`: register `state`, clear line index and flags, go SCAN.
- SCAN: L = 2N+2 cycles; line index i = 0..L-1: i<N row i; N≤i<2N column i−N; i=2N main diagonal (r=c); i=2N+1 anti-diagonal (c=N−1−r). Each cycle sets sticky `win_a` if all N cells of line i are 01, `win_o` if all are 10. After i=L−1 go DONE.
- Empty/invalid detection: combinational over the registered board, latched into `any_empty` / `bad_cell` at the SCAN→DONE transition.
- Result priority on entering DONE: `win_a` → R_WIN/10; else `win_o` → R_LOSE/11; else `any_empty`=0 → R_FULL/01; else R_CONT/00. Agent win takes precedence when both players hold a line. Code 11 cells count as occupied and never complete a line.
- DONE: `out_valid`=1; `reward`, `status`, `bad_cell` stable. On `out_ready`: go IDLE.
- `in_valid` while `in_ready`=0 is ignored (no queueing); `state` is sampled only at acceptance.
- Parameter values are sign-extended/truncated to RW bits.

## Timing
- Reset (while `rst`=1 and cycle after): FSM IDLE, `in_ready`=0 during reset then 1, `out_valid`=0, `reward`=0, `status`=00, `bad_cell`=0, line index 0, flags cleared.
- Acceptance at edge k → SCAN during cycles k+1..k+L → `out_valid` high from cycle k+L+1. N=3: 9 cycles; N=4: 11 cycles.
- `out_valid`&&`out_ready` at edge m → `in_ready`=1 in cycle m+1; earliest next acceptance at edge m+1. Max throughput one board per L+2 cycles.
- `reward`/`status`/`bad_cell` hold their last values in IDLE and SCAN; update only on SCAN→DONE.
- `rst` in SCAN or DONE: abort, no `out_valid`, outputs to reset values next cycle.
- Back-pressure: `out_ready`=0 holds DONE indefinitely with outputs stable.

## Test plan
- N=3, agent row 0 (`state`=18'h00015), `out_ready`=1 → `out_valid` 9 cycles after accept, `reward`=8'h02, `status`=10.
- N=3, opponent main diagonal (`state`=18'h20202) → `reward`=8'hFE, `status`=11.
- N=3 full board, no line (rows 1/2/1, 2/1/2, 2/1/2 in column order per row) → `reward`=0, `status`=01; same board with one cell 00 → `reward`=1, `status`=00.
- N=3 both players hold a line (agent row 0, opponent row 2) → agent priority, `reward`=2, `status`=10; board with one 11 cell and otherwise empty → `status`=00, `bad_cell`=1.
- N=4, agent anti-diagonal (cells (0,3),(1,2),(2,1),(3,0)=01) → `out_valid` 11 cycles after accept, `status`=10; hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0, `in_valid` pulses ignored.
- Assert `rst` in SCAN cycle 4 → no `out_valid`, `reward`=0, `status`=00, `in_ready`=1 the cycle after `rst` drops; next board evaluates correctly.
